// File: rtl/rho_pi_if.sv
// Streaming interface of the rho/pi engine: slice input, slice output and status.
// The engine connects through the slave modport; the producer/consumer uses master.
interface rho_pi_if;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_slice;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_slice;
    logic        busy;
    logic        done;

    modport slave (
        input  mode, in_valid, in_slice, out_ready,
        output in_ready, out_valid, out_slice, busy, done
    );

    modport master (
        output mode, in_valid, in_slice, out_ready,
        input  in_ready, out_valid, out_slice, busy, done
    );
endinterface

// File: rtl/rho_pi_engine.sv
// Sequential Keccak rho/pi stage: buffers LANE_W 25-bit slices, permutes one lane
// per cycle into a second buffer, then streams the result back out slice by slice.
module rho_pi_engine #(
    parameter int LANE_W = 64
) (
    input logic     clk,
    input logic     rst,
    rho_pi_if.slave bus
);
    localparam int ZW = $clog2(LANE_W);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PERMUTE, S_UNLOAD} state_t;

    state_t        state_q;
    logic [1:0]    mode_q;
    logic [ZW-1:0] z_in_q;
    logic [ZW-1:0] z_out_q;
    logic [4:0]    lane_q;
    logic          out_valid_q;
    logic [24:0]   out_slice_q;
    logic          done_q;

    logic [24:0]   a_q [LANE_W];
    logic [24:0]   b_q [LANE_W];

    logic [LANE_W-1:0] lane_src;
    logic [LANE_W-1:0] lane_rot;
    logic [5:0]        rho_full;
    logic [ZW-1:0]     rot_amt;
    logic [4:0]        dst_lane;
    logic [ZW-1:0]     z_out_d;
    logic              in_ready_d;
    logic              in_xfer;

    function automatic logic [5:0] rho_off(input logic [4:0] i);
        case (i)
            5'd0:  return 6'd0;   5'd1:  return 6'd1;   5'd2:  return 6'd62;
            5'd3:  return 6'd28;  5'd4:  return 6'd27;  5'd5:  return 6'd36;
            5'd6:  return 6'd44;  5'd7:  return 6'd6;   5'd8:  return 6'd55;
            5'd9:  return 6'd20;  5'd10: return 6'd3;   5'd11: return 6'd10;
            5'd12: return 6'd43;  5'd13: return 6'd25;  5'd14: return 6'd39;
            5'd15: return 6'd41;  5'd16: return 6'd45;  5'd17: return 6'd15;
            5'd18: return 6'd21;  5'd19: return 6'd8;   5'd20: return 6'd18;
            5'd21: return 6'd2;   5'd22: return 6'd61;  5'd23: return 6'd56;
            5'd24: return 6'd14;  default: return 6'd0;
        endcase
    endfunction

    // Lane (x,y) moves to lane y + 5*((2x+3y) mod 5), tabulated by source index x+5y.
    function automatic logic [4:0] pi_dst(input logic [4:0] i);
        case (i)
            5'd0:  return 5'd0;   5'd1:  return 5'd10;  5'd2:  return 5'd20;
            5'd3:  return 5'd5;   5'd4:  return 5'd15;  5'd5:  return 5'd16;
            5'd6:  return 5'd1;   5'd7:  return 5'd11;  5'd8:  return 5'd21;
            5'd9:  return 5'd6;   5'd10: return 5'd7;   5'd11: return 5'd17;
            5'd12: return 5'd2;   5'd13: return 5'd12;  5'd14: return 5'd22;
            5'd15: return 5'd23;  5'd16: return 5'd8;   5'd17: return 5'd18;
            5'd18: return 5'd3;   5'd19: return 5'd13;  5'd20: return 5'd14;
            5'd21: return 5'd24;  5'd22: return 5'd9;   5'd23: return 5'd19;
            5'd24: return 5'd4;   default: return 5'd0;
        endcase
    endfunction

    assign rho_full   = rho_off(lane_q);
    assign rot_amt    = mode_q[0] ? rho_full[ZW-1:0] : '0;
    assign dst_lane   = mode_q[1] ? pi_dst(lane_q) : lane_q;
    assign z_out_d    = z_out_q + ZW'(1);
    assign in_ready_d = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign in_xfer    = bus.in_valid && in_ready_d;

    // Gather the current lane across all slices, then rotate it: the bit landing
    // at z came from z - R, and ZW-bit subtraction gives the modular wrap for free.
    generate
        for (genvar gi = 0; gi < LANE_W; gi++) begin : g_lane
            localparam logic [ZW-1:0] ZI = ZW'(gi);
            assign lane_src[gi] = a_q[gi][lane_q];
            assign lane_rot[gi] = lane_src[ZI - rot_amt];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            a_q[z_in_q] <= bus.in_slice;
        end
        if (state_q == S_PERMUTE) begin
            for (int z = 0; z < LANE_W; z++) begin
                b_q[z][dst_lane] <= lane_rot[z];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'b00;
            z_in_q      <= '0;
            z_out_q     <= '0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_slice_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_xfer) begin
                        mode_q  <= bus.mode;
                        z_in_q  <= ZW'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_xfer) begin
                        z_in_q <= z_in_q + ZW'(1);
                        if (z_in_q == ZW'(LANE_W - 1)) begin
                            lane_q  <= '0;
                            state_q <= S_PERMUTE;
                        end
                    end
                end
                S_PERMUTE: begin
                    if (lane_q == 5'd24) begin
                        lane_q  <= '0;
                        z_out_q <= '0;
                        state_q <= S_UNLOAD;
                    end else begin
                        lane_q <= lane_q + 5'd1;
                    end
                end
                S_UNLOAD: begin
                    // First UNLOAD cycle primes the output register once lane 24 has landed.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_slice_q <= b_q[z_out_q];
                    end else if (bus.out_ready) begin
                        if (z_out_q == ZW'(LANE_W - 1)) begin
                            out_valid_q <= 1'b0;
                            out_slice_q <= '0;
                            z_out_q     <= '0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            z_out_q     <= z_out_d;
                            out_slice_q <= b_q[z_out_d];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_slice = out_slice_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rho_pi_engine.sv
// Bench for rho_pi_engine: 64-bit and 8-bit lane instances, table-driven single-bit
// frames, model-checked random frames with output stalls, and a mid-permute reset.
module tb_rho_pi_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rho_pi_if bif64();
    rho_pi_if bif8();

    rho_pi_engine #(.LANE_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bif64));
    rho_pi_engine #(.LANE_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bif8));

    logic        sel8 = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_ready = 1'b1;
    logic [24:0] drv_slice = '0;
    logic [1:0]  drv_mode = '0;

    assign bif64.in_valid  = drv_valid & ~sel8;
    assign bif8.in_valid   = drv_valid & sel8;
    assign bif64.in_slice  = drv_slice;
    assign bif8.in_slice   = drv_slice;
    assign bif64.mode      = drv_mode;
    assign bif8.mode       = drv_mode;
    assign bif64.out_ready = drv_ready & ~sel8;
    assign bif8.out_ready  = drv_ready & sel8;

    wire        cur_in_ready  = sel8 ? bif8.in_ready  : bif64.in_ready;
    wire        cur_out_valid = sel8 ? bif8.out_valid : bif64.out_valid;
    wire [24:0] cur_out_slice = sel8 ? bif8.out_slice : bif64.out_slice;
    wire        cur_busy      = sel8 ? bif8.busy      : bif64.busy;
    wire        cur_done      = sel8 ? bif8.done      : bif64.done;

    int total = 0;
    int passed = 0;

    logic [24:0] frame_in [64];
    logic [24:0] exp_out [64];
    logic [24:0] sb_q [$];
    int rho_tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    typedef struct {
        bit       w8;
        logic [1:0] mode;
        int       in_z;
        int       in_bit;
        int       exp_z;
        int       exp_bit;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: every set bit of the frame is placed by the rho/pi definitions directly.
    task automatic model(input logic [1:0] m, input int w);
        int x, y, zz, d;
        for (int z = 0; z < 64; z++) exp_out[z] = '0;
        for (int z = 0; z < w; z++) begin
            for (int b = 0; b < 25; b++) begin
                if (frame_in[z][b]) begin
                    x  = b % 5;
                    y  = b / 5;
                    zz = m[0] ? (z + rho_tab[b]) % w : z;
                    d  = m[1] ? y + 5 * ((2 * x + 3 * y) % 5) : b;
                    exp_out[zz][d] = 1'b1;
                end
            end
        end
        for (int z = 0; z < w; z++) sb_q.push_back(exp_out[z]);
    endtask

    task automatic send(input logic [1:0] m, input int w);
        logic rdy;
        int n;
        for (int z = 0; z < w; z++) begin
            drv_valid = 1'b1;
            drv_slice = frame_in[z];
            drv_mode  = (z == 0) ? m : 2'($urandom);
            n = 0;
            do begin
                @(negedge clk);
                rdy = cur_in_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!rdy && n < 100);
            if (!rdy) chk("send_ready_timeout", {63'd0, rdy}, 64'd1);
        end
        drv_valid = 1'b0;
        drv_slice = '0;
    endtask

    task automatic collect(input int w, input bit rnd, input string tag);
        int got = 0;
        int k = 0;
        int first = -1;
        logic [24:0] held = '0;
        bit stalled = 1'b0;
        logic [24:0] e;
        while (got < w && k < 4000) begin
            drv_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drv_valid = 1'b1;
            drv_slice = 25'($urandom);
            @(negedge clk);
            if (cur_out_valid) begin
                if (first < 0) begin
                    first = k;
                    chk({tag, " latency"}, 64'(k), 64'd26);
                end
                if (stalled) chk({tag, " stall_hold"}, {39'd0, cur_out_slice}, {39'd0, held});
                if (drv_ready) begin
                    if (sb_q.size() > 0) e = sb_q.pop_front();
                    else e = 'x;
                    chk($sformatf("%s slice%0d", tag, got), {39'd0, cur_out_slice}, {39'd0, e});
                    got++;
                    stalled = 1'b0;
                    if (got == w) drv_valid = 1'b0;
                end else begin
                    held = cur_out_slice;
                    stalled = 1'b1;
                end
            end else begin
                chk({tag, " idle_zero"}, {39'd0, cur_out_slice}, 64'd0);
            end
            @(posedge clk);
            #1;
            k++;
        end
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        chk({tag, " slice_count"}, 64'(got), 64'(w));
        @(negedge clk);
        chk({tag, " done_pulse"}, {63'd0, cur_done}, 64'd1);
        chk({tag, " busy_after"}, {63'd0, cur_busy}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, " done_single"}, {63'd0, cur_done}, 64'd0);
        @(posedge clk);
        #1;
        $display("frame %s width=%0d slices=%0d first_valid_after=%0d", tag, w, got, first);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"},      {63'd0, cur_busy},      64'd0);
        chk({tag, " in_ready"},  {63'd0, cur_in_ready},  64'd1);
        chk({tag, " out_valid"}, {63'd0, cur_out_valid}, 64'd0);
        chk({tag, " out_slice"}, {39'd0, cur_out_slice}, 64'd0);
        chk({tag, " done"},      {63'd0, cur_done},      64'd0);
    endtask

    initial begin
        int w;
        int bad;
        logic [24:0] e;
        logic [1:0] m;

        vecs[0]  = '{1'b0, 2'b00, 0,  0,  0, 0};
        vecs[1]  = '{1'b0, 2'b01, 0,  1,  1, 1};
        vecs[2]  = '{1'b0, 2'b01, 5,  2,  3, 2};
        vecs[3]  = '{1'b0, 2'b10, 7,  1,  7, 10};
        vecs[4]  = '{1'b0, 2'b10, 0,  24, 0, 4};
        vecs[5]  = '{1'b0, 2'b11, 63, 1,  0, 10};
        vecs[6]  = '{1'b0, 2'b11, 0,  0,  0, 0};
        vecs[7]  = '{1'b1, 2'b01, 3,  2,  1, 2};
        vecs[8]  = '{1'b1, 2'b01, 6,  5,  2, 5};
        vecs[9]  = '{1'b1, 2'b11, 7,  24, 5, 4};
        vecs[10] = '{1'b1, 2'b10, 2,  3,  2, 5};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sel8 = 1'b0;
        @(negedge clk);
        check_idle("reset64");
        sel8 = 1'b1;
        @(negedge clk);
        check_idle("reset8");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int t = 0; t < NV; t++) begin
            sel8 = vecs[t].w8;
            w = vecs[t].w8 ? 8 : 64;
            for (int z = 0; z < 64; z++) frame_in[z] = '0;
            frame_in[vecs[t].in_z][vecs[t].in_bit] = 1'b1;
            for (int z = 0; z < w; z++) begin
                e = '0;
                if (z == vecs[t].exp_z) e[vecs[t].exp_bit] = 1'b1;
                sb_q.push_back(e);
            end
            send(vecs[t].mode, w);
            collect(w, 1'b0, $sformatf("vec%0d", t));
        end

        sel8 = 1'b0;
        for (int z = 0; z < 64; z++) begin
            frame_in[z] = '1;
            sb_q.push_back('1);
        end
        send(2'b11, 64);
        collect(64, 1'b0, "all_ones");

        for (int r = 0; r < 3; r++) begin
            sel8 = (r == 2);
            w = sel8 ? 8 : 64;
            m = 2'($urandom);
            for (int z = 0; z < 64; z++) frame_in[z] = 25'($urandom);
            model(m, w);
            send(m, w);
            collect(w, 1'b1, $sformatf("rand%0d_mode%0d", r, m));
        end

        // Abort during PERMUTE at lane 10: nothing may reach the output afterwards.
        sel8 = 1'b0;
        sb_q.delete();
        for (int z = 0; z < 64; z++) frame_in[z] = 25'($urandom);
        send(2'b11, 64);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (cur_out_valid || cur_done || cur_busy) bad++;
        end
        chk("post_reset_quiet", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        $display("frame mid_reset aborted at lane 10");

        for (int z = 0; z < 64; z++) frame_in[z] = 25'($urandom);
        model(2'b11, 64);
        send(2'b11, 64);
        collect(64, 1'b1, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rho_pi_engine.md
Name: rho_pi_engine

Overview:
- Sequential, parametrised Keccak rho/pi stage for the matrix-encoder permutation datapath.
- Accepts a full state as LANE_W streamed 25-bit slices (z = 0..LANE_W-1) into an internal buffer.
- Applies the selected rho/pi mode lane-by-lane over 25 cycles, then streams the permuted state back out slice-by-slice.
- Generalises the fixed 64-bit rotate step to any power-of-two lane width, adds selectable modes and valid/ready handshakes on both sides.

Parameters:
- LANE_W, 64, lane width / slices per state; power of two, 8..64. Internal localparam ZW = log2(LANE_W).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mode  in  2  00 bypass, 01 rho only, 10 pi only, 11 rho then pi; sampled on first accepted slice
- in_valid  in  1  in_slice valid
- in_ready  out  1  engine can accept a slice
- in_slice  in  25  slice; bit b = x + 5y, x,y in 0..4
- out_valid  out  1  out_slice valid
- out_ready  in  1  consumer accepts out_slice
- out_slice  out  25  permuted slice, same bit mapping as in_slice
- busy  out  1  high in LOAD, PERMUTE, UNLOAD
- done  out  1  one-cycle pulse after last output slice accepted

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, all counters 0, in_ready=1, out_valid=0, out_slice=0, busy=0, done=0. Buffer contents are not cleared (don't-care).
- Reset mid-operation: aborts any state and returns to IDLE on the next edge. The partial state is discarded and no done pulse is issued.
- Handshakes: a transfer occurs when valid&&ready on a clk edge. in_ready=1 only in IDLE and LOAD.
- IDLE: first input transfer writes buffer A[z=0], latches mode, moves to LOAD with z_in=1.
- LOAD: each transfer writes A[z_in], z_in++. On the transfer with z_in=LANE_W-1, move to PERMUTE with lane counter i=0.
- PERMUTE: 25 cycles, i=0..24, exactly one lane per cycle.
  - Source lane (x,y) = (i%5, i/5); read bit i of A[z] for all z.
  - If rho is enabled, bit at z goes to z' = (z + R[i]) mod LANE_W. Otherwise z' = z.
  - If pi is enabled, destination index = y + 5*((2x+3y) mod 5). Otherwise destination = i.
  - Write the resulting lane into buffer B.
  - After i=24, move to UNLOAD with z_out=0.
- Rho offsets R[0..24] = 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14, reduced mod LANE_W. Modular arithmetic is on ZW bits, so wrap is natural truncation.
- Latency: last input transfer at edge T, so PERMUTE spans T+1..T+25 and out_valid=1 from edge T+26.
- UNLOAD:
  - out_valid=1 and out_slice=B[z_out], registered.
  - Each output transfer increments z_out.
  - out_slice and out_valid hold stable while out_ready=0.
  - On the transfer with z_out=LANE_W-1, out_valid drops and the engine goes to IDLE, with done=1 for exactly one cycle.
- A new frame may be accepted in the same cycle done is high.
- out_slice=0 whenever out_valid=0.
- mode changes after latching have no effect until the next frame.
- in_valid while in_ready=0 is ignored; no data is captured.

Test Plan:
- LANE_W=64, mode=00: frame with slice z=0 = 25'h1, all other slices 0 -> output slice 0 = 25'h1, all others 0; first out_valid exactly 26 cycles after last input transfer; done pulses once after 64th output transfer.
- LANE_W=64, mode=01: bit 1 set at z=0 -> output bit 1 at z=1 only. Separately, bit 2 set at z=5 -> bit 2 at z=3 (67 mod 64).
- LANE_W=64, mode=10: bit 1 (x=1,y=0) at z=7 -> bit 10 at z=7 only. Bit 24 (x=4,y=4) at z=0 -> bit 4+5*((8+12)%5)=4 at z=0.
- LANE_W=64, mode=11: bit 1 at z=63 -> bit 10 at z=0 (rotate wrap plus pi). All-ones frame -> all-ones output.
- LANE_W=8, mode=01: bit 2 (R=62, 62 mod 8 = 6) at z=3 -> bit 2 at z=1. Bit 5 (R=36, 36 mod 8 = 4) at z=6 -> z=2.
- Control and reset:
  - out_ready toggled 1/0 pseudo-randomly -> out_slice stable while stalled and no slice lost.
  - rst asserted at PERMUTE i=10 -> next cycle busy=0, in_ready=1, out_valid=0, done=0.
  - A subsequent full frame then completes correctly.
